// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line responder: receives 48-bit host commands and answers with R1-format frames.
// Optional macro SD_RESP_CRC_CHECK_EN: when defined, commands with a bad CRC7 are rejected.
module sd_card_cmd_responder #(
    parameter int NCR      = 2,
    parameter bit NO_RESP0 = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        cmd_in,
    output logic        cmd_out,
    output logic        cmd_oe,
    input  logic [31:0] card_status,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        cmd_valid,
    output logic        cmd_err,
    output logic        busy
);

`ifdef SD_RESP_CRC_CHECK_EN
    localparam bit CRC_CHECK = 1'b1;
`else
    localparam bit CRC_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RECV, CHECK, WAIT, SEND} state_t;

    state_t      state, state_nx;
    logic [47:0] rx_sh;
    logic [47:0] tx_sh;
    logic [5:0]  cnt;      // rx bit count, WAIT cycle count and tx bit count
    logic        crc_ok;
    logic        frame_ok;
    logic [39:0] resp_body;
    logic [47:0] resp_frame;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    assign crc_ok     = (crc7(rx_sh[47:8]) == rx_sh[7:1]);
    assign frame_ok   = rx_sh[46] & rx_sh[0] & (crc_ok | ~CRC_CHECK);
    assign resp_body  = {2'b00, rx_sh[45:40], card_status};
    assign resp_frame = {resp_body, crc7(resp_body), 1'b1};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cmd_valid = 1'b0;
        cmd_err   = 1'b0;
        cmd_oe    = 1'b0;
        cmd_out   = 1'b1;
        busy      = (state != IDLE);
        case (state)
            IDLE:  if (!cmd_in) state_nx = RECV;
            RECV:  if (cnt == 6'd47) state_nx = CHECK;
            CHECK: begin
                if (!frame_ok) begin
                    cmd_err  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cmd_valid = 1'b1;
                    if (NO_RESP0 && rx_sh[45:40] == 6'd0) state_nx = IDLE;
                    else                                   state_nx = WAIT;
                end
            end
            WAIT:  if (cnt == 6'(NCR - 1)) state_nx = SEND;
            SEND: begin
                cmd_oe  = 1'b1;
                cmd_out = tx_sh[47];
                if (cnt == 6'd47) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_sh     <= '0;
            tx_sh     <= '0;
            cnt       <= '0;
            cmd_index <= '0;
            cmd_arg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rx_sh <= {47'd0, cmd_in};
                    cnt   <= 6'd1;
                end
                RECV: begin
                    rx_sh <= {rx_sh[46:0], cmd_in};
                    cnt   <= cnt + 6'd1;
                end
                CHECK: begin
                    cnt   <= '0;
                    tx_sh <= resp_frame;
                    if (frame_ok) begin
                        cmd_index <= rx_sh[45:40];
                        cmd_arg   <= rx_sh[39:8];
                    end
                end
                WAIT: cnt <= (cnt == 6'(NCR - 1)) ? 6'd0 : cnt + 6'd1;
                SEND: begin
                    tx_sh <= {tx_sh[46:0], 1'b1};
                    cnt   <= cnt + 6'd1;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule
